fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised LC-3 instruction fetch with prefetch queue; successor to the single-register PC fetch.
//  Issues word reads to instruction memory over a req/ack handshake and buffers returned words with their PC.
//  Supplies decode through a valid/ready port; a branch/jump redirect flushes the queue and restarts fetch.
//  Sits between the instruction-memory port and decode, in the same position as the current fetch block.
// PARAMETERS
//  ADDR_W    16       PC / memory address width
//  DATA_W    16       instruction word width
//  DEPTH     4        prefetch queue entries (power of two, >=2)
//  RESET_PC  16'h3000 PC loaded on reset (width ADDR_W)
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst            in   1       synchronous, active-low reset
//  enable_fetch   in   1       1 = new memory requests may be issued; 0 = hold, no new request
//  mem_req        out  1       read request, held high until mem_ack
//  mem_addr       out  ADDR_W  read address; 0 when mem_req=0
//  mem_ack        in   1       read data valid this cycle; completes request
//  mem_rdata      in   DATA_W  instruction word, sampled when mem_ack=1
//  redirect       in   1       control transfer taken (br_taken equivalent), 1-cycle pulse
//  redirect_addr  in   ADDR_W  target PC for redirect (taddr equivalent)
//  inst_valid     out  1       queue head valid
//  inst_ready     in   1       decode accepts head (pop when inst_valid & inst_ready)
//  inst           out  DATA_W  head instruction
//  inst_pc        out  ADDR_W  PC of head instruction
//  inst_npc       out  ADDR_W  inst_pc + 1, modulo 2^ADDR_W
// BEHAVIOUR
//  Reset (rst=0 at posedge): fetch_pc=RESET_PC, queue empty, state IDLE; mem_req=0, mem_addr=0, inst_valid=0,
//   inst/inst_pc/inst_npc=0. Reset overrides everything incl. redirect; late mem_ack after reset ignored.
//  FSM states: IDLE, REQ, DRAIN.
//   IDLE->REQ: enable_fetch=1, redirect=0, and count < DEPTH (one slot reserved per outstanding req).
//    mem_req rises next cycle, mem_addr=fetch_pc.
//   REQ: mem_req=1, mem_addr stable until ack. On mem_ack: push {fetch_pc, mem_rdata}, fetch_pc+=1,
//    go IDLE (earliest next request one cycle later; max one outstanding request).
//   REQ + redirect, no ack same cycle -> DRAIN; fetch_pc=redirect_addr, queue flushed.
//   REQ + redirect + ack same cycle: data discarded, no push, fetch_pc=redirect_addr, -> IDLE.
//   DRAIN: mem_req held 1 with old address until mem_ack; data discarded; -> IDLE. Further redirects in
//    DRAIN only update fetch_pc.
//  Redirect in IDLE: flush queue, fetch_pc=redirect_addr; no request issued that cycle.
//  Queue: FIFO, head on inst/inst_pc; push and pop same cycle leave count unchanged.
//   Flush beats simultaneous pop and push. Pop when empty impossible (gated by inst_valid).
//  Latency: redirect at cycle N -> mem_req with target at N+2 (IDLE) -> inst_valid earliest cycle after ack.
//  Arithmetic: fetch_pc and inst_npc wrap ADDR_W'h...FFFF -> 0, no flag.
//  enable_fetch=0 never aborts an outstanding request; queue keeps draining to decode.
//  No tri-state outputs; all outputs driven in every state.
// STRUCTURE
//  Package lc3_fetch_pkg: FSM state enum (IDLE/REQ/DRAIN), default RESET_PC, default ADDR_W/DATA_W.
//  One sub-module: fetch_queue (sync FIFO, width ADDR_W+DATA_W, depth DEPTH, push/pop/flush, count).
//  Top level holds fetch_pc, FSM, request/slot-reservation logic and npc adder.
// TESTING
//  1 Reset: rst=0 two cycles, release, enable_fetch=1 -> mem_req=1, mem_addr=16'h3000 on 2nd cycle after.
//  2 Stream: 1-cycle ack, inst_ready=1, words A..D -> inst_pc 3000,3001,3002,3003 in order, npc=pc+1.
//  3 Full: inst_ready=0, DEPTH=4 -> exactly 4 acks, then mem_req stays 0; one pop -> one new request.
//  4 Redirect during wait: ack delayed 3 cycles, redirect to 16'h4000 -> DRAIN, late word dropped,
//     next mem_addr=16'h4000, inst_valid=0 until its ack.
//  5 Redirect + ack same cycle -> no push, queue empty, next request at target.
//  6 Wrap: redirect to 16'hFFFF -> inst_pc FFFF with inst_npc 0000, next fetch mem_addr=16'h0000.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and defaults for the LC-3 prefetching instruction fetch unit.
package lc3_fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs; flush dominates push and pop.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// LC-3 instruction fetch: one outstanding memory read at a time, results queued for decode.
module fetch_prefetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_fetch,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_npc
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic                     mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                     q_push, q_pop, q_flush;
    logic [ADDR_W+DATA_W-1:0] q_head;
    logic [CNT_W-1:0]         q_count;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;
        q_pop      = inst_valid && inst_ready;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = redirect_addr;
                end else if (enable_fetch && (q_count < DEPTH_C)) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                    if (redirect) begin
                        q_flush    = 1'b1;
                        fetch_pc_d = redirect_addr;
                    end else begin
                        q_push     = 1'b1;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end else if (redirect) begin
                    // Memory still owes us a word; keep the handshake open and drop it later.
                    state_d    = ST_DRAIN;
                    q_flush    = 1'b1;
                    fetch_pc_d = redirect_addr;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_addr;
                end
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    fetch_queue #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({fetch_pc_q, mem_rdata}),
        .pop       (q_pop),
        .flush     (q_flush),
        .head      (q_head),
        .count     (q_count)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = (q_count != '0);
    assign inst       = inst_valid ? q_head[DATA_W-1:0] : '0;
    assign inst_pc    = inst_valid ? q_head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign inst_npc   = inst_valid ? q_head[ADDR_W+DATA_W-1:DATA_W] + 1'b1 : '0;

endmodule
